// File: rtl/nrs_pilot_demapper_pkg.sv
// Shared channel-estimation constants for the NRS pilot demapper:
// pilot symbol positions, subcarrier grid size, bank-state encoding and
// the small arithmetic helpers used for pilot selection.
package nrs_pilot_demapper_pkg;

  // NRS (port 0) pilot symbols within a subframe
  localparam logic [3:0] NRS_SYM_S0A = 4'd5;
  localparam logic [3:0] NRS_SYM_S0B = 4'd6;
  localparam logic [3:0] NRS_SYM_S1A = 4'd12;
  localparam logic [3:0] NRS_SYM_S1B = 4'd13;

  // Subcarriers per resource block; the two pilots of a symbol sit half a block apart
  localparam logic [3:0] NUM_SC         = 4'd12;
  localparam logic [3:0] NRS_SC_SPACING = NUM_SC >> 1;

  // Pilots held per slot bank: 2 symbols x 2 subcarriers
  localparam int PILOTS_PER_SLOT = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Cell shift folded into 0..5 (v_shift mod 6 for a 3-bit input)
  function automatic logic [2:0] fold_shift(input logic [2:0] v);
    return (v >= 3'd6) ? (v - 3'd6) : v;
  endfunction

  // (v + 3) mod 6 for v in 0..5: second pilot symbol is offset by 3 subcarriers
  function automatic logic [2:0] add3_mod6(input logic [2:0] v);
    return (v >= 3'd3) ? (v - 3'd3) : (v + 3'd3);
  endfunction

endpackage

// File: rtl/nrs_pilot_bank.sv
// One slot bank of NRS pilots: 4-entry I/Q register file, a written-entry
// mask so rewrites of the same entry are not counted twice, and the
// EMPTY -> FILLING -> FULL -> EMPTY occupancy FSM.
module nrs_pilot_bank
  import nrs_pilot_demapper_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [1:0]          wr_entry,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic                clr,
  input  logic [1:0]          rd_entry,
  output logic [2*DATA_W-1:0] rd_data,
  output logic                full,
  output logic                drop
);

  bank_state_t         state;
  bank_state_t         state_next;
  logic [3:0]          mask;
  logic [3:0]          mask_next;
  logic                accept;
  logic [2*DATA_W-1:0] mem [PILOTS_PER_SLOT];

  // State register: occupancy state and written-entry mask
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state <= BANK_EMPTY;
      mask  <= 4'h0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
    end
  end

  // Next-state logic: a clear returns to EMPTY, accepted writes fill the mask
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_next = state;
    mask_next  = mask;
    if (clr) begin
      state_next = BANK_EMPTY;
      mask_next  = 4'h0;
    end else if (accept) begin
      mask_next  = mask | (4'b0001 << wr_entry);
      state_next = (mask_next == 4'hF) ? BANK_FULL : BANK_FILLING;
    end
  end

  // Output logic: writes are taken unless the bank is FULL, in which case they are dropped
  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    full   = (state == BANK_FULL);
    if (wr_en) begin
      if (state == BANK_FULL) drop   = 1'b1;
      else                    accept = 1'b1;
    end
  end

  // Pilot storage; contents are only meaningful once the mask says so
  always_ff @(posedge clk) begin
    // NOTE: the register file is deliberately not reset; occupancy is tracked
    // by state/mask, so stale data is never served.
    if (accept) mem[wr_entry] <= wr_data;
  end

  assign rd_data = mem[rd_entry];

endmodule

// File: rtl/nrs_pilot_demapper.sv
// NRS pilot demapper: classifies the post-FFT RE stream, captures the
// port-0 pilots of each subframe into two slot banks, and serves them to
// the channel-estimation control with a fixed one-cycle read latency.
module nrs_pilot_demapper
  import nrs_pilot_demapper_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        v_shift,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [3:0]        in_sym,
  input  logic [3:0]        in_sc,
  input  logic [DATA_W-1:0] in_re_i,
  input  logic [DATA_W-1:0] in_re_q,
  input  logic              demap_read,
  input  logic [3:0]        col,
  input  logic [1:0]        nrs_index_addr,
  output logic              demap_ready,
  output logic              pilot_valid,
  output logic [DATA_W-1:0] pilot_i,
  output logic [DATA_W-1:0] pilot_q,
  output logic              overrun,
  output logic              rd_err
);

  // Write side
  logic [2:0] vs_reg;
  logic [2:0] vs_eff;
  logic [3:0] k0;
  logic [3:0] k1;
  logic       sym_a;
  logic       sym_b;
  logic       hit0;
  logic       hit1;
  logic       is_pilot;
  logic       wr_bank;
  logic [1:0] wr_entry;
  logic [1:0] bank_wr_en;

  // Read side
  logic       rd_bank;
  logic [1:0] rd_cnt;
  logic       col_ok;
  logic       col_is_b;
  logic       rd_bank_sel;
  logic       read_legal;
  logic       read_last;
  logic [1:0] bank_clr;

  // Bank status / data
  logic [1:0]          bank_full;
  logic [1:0]          bank_drop;
  logic [2*DATA_W-1:0] bank_rd_data [2];
  logic [2*DATA_W-1:0] rd_sel_data;

  // Cell shift register, loaded at the start of every subframe
  always_ff @(posedge clk) begin
    if (rst)                      vs_reg <= 3'd0;
    else if (in_valid && in_sof)  vs_reg <= fold_shift(v_shift);
  end

  // The first RE of a subframe is classified with its own shift, not the stale one
  assign vs_eff = (in_valid && in_sof) ? fold_shift(v_shift) : vs_reg;

  // Pilot classification: which symbol, which subcarrier, which bank/entry
  always_comb begin
    sym_a    = (in_sym == NRS_SYM_S0A) || (in_sym == NRS_SYM_S1A);
    sym_b    = (in_sym == NRS_SYM_S0B) || (in_sym == NRS_SYM_S1B);
    k0       = sym_b ? {1'b0, add3_mod6(vs_eff)} : {1'b0, vs_eff};
    k1       = k0 + NRS_SC_SPACING;
    hit0     = (sym_a || sym_b) && (in_sc == k0);
    hit1     = (sym_a || sym_b) && (in_sc == k1);
    is_pilot = in_valid && (hit0 || hit1);
    wr_bank  = (in_sym == NRS_SYM_S1A) || (in_sym == NRS_SYM_S1B);
    wr_entry = {sym_b, hit1};
    bank_wr_en[0] = is_pilot && !wr_bank;
    bank_wr_en[1] = is_pilot &&  wr_bank;
  end

  // Read legality: valid column, current read bank, bank FULL, address matches symbol
  always_comb begin
    col_ok      = (col == NRS_SYM_S0A) || (col == NRS_SYM_S0B) ||
                  (col == NRS_SYM_S1A) || (col == NRS_SYM_S1B);
    col_is_b    = (col == NRS_SYM_S0B) || (col == NRS_SYM_S1B);
    rd_bank_sel = (col >= 4'd7);
    read_legal  = demap_read && col_ok && (rd_bank_sel == rd_bank) &&
                  bank_full[rd_bank_sel] && (nrs_index_addr[1] == col_is_b);
    read_last   = read_legal && (rd_cnt == 2'd3);
    bank_clr[0] = read_last && !rd_bank;
    bank_clr[1] = read_last &&  rd_bank;
    rd_sel_data = bank_rd_data[rd_bank_sel];
  end

  nrs_pilot_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bank_wr_en[0]),
    .wr_entry (wr_entry),
    .wr_data  ({in_re_i, in_re_q}),
    .clr      (bank_clr[0]),
    .rd_entry (nrs_index_addr),
    .rd_data  (bank_rd_data[0]),
    .full     (bank_full[0]),
    .drop     (bank_drop[0])
  );

  nrs_pilot_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bank_wr_en[1]),
    .wr_entry (wr_entry),
    .wr_data  ({in_re_i, in_re_q}),
    .clr      (bank_clr[1]),
    .rd_entry (nrs_index_addr),
    .rd_data  (bank_rd_data[1]),
    .full     (bank_full[1]),
    .drop     (bank_drop[1])
  );

  // Read bookkeeping: four legal reads drain a bank and hand over to the other
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank <= 1'b0;
      rd_cnt  <= 2'd0;
    end else if (read_legal) begin
      if (read_last) begin
        rd_bank <= ~rd_bank;
        rd_cnt  <= 2'd0;
      end else begin
        rd_cnt  <= rd_cnt + 2'd1;
      end
    end
  end

  // Output register: one-cycle read response, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      demap_ready <= 1'b0;
      pilot_valid <= 1'b0;
      pilot_i     <= '0;
      pilot_q     <= '0;
      overrun     <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      demap_ready <= bank_full[rd_bank];
      pilot_valid <= demap_read;
      rd_err      <= demap_read && !read_legal;
      overrun     <= overrun || (|bank_drop);
      if (read_legal) begin
        pilot_i <= rd_sel_data[2*DATA_W-1:DATA_W];
        pilot_q <= rd_sel_data[DATA_W-1:0];
      end else if (demap_read) begin
        pilot_i <= '0;
        pilot_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nrs_pilot_demapper.sv
// Bench for nrs_pilot_demapper: directed subframes and reads, a subframe-level
// pilot model compared against the DUT every cycle, plus literal pilot values.
module tb_nrs_pilot_demapper;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        v_shift;
  logic              in_valid;
  logic              in_sof;
  logic [3:0]        in_sym;
  logic [3:0]        in_sc;
  logic [DATA_W-1:0] in_re_i;
  logic [DATA_W-1:0] in_re_q;
  logic              demap_read;
  logic [3:0]        col;
  logic [1:0]        nrs_index_addr;
  logic              demap_ready;
  logic              pilot_valid;
  logic [DATA_W-1:0] pilot_i;
  logic [DATA_W-1:0] pilot_q;
  logic              overrun;
  logic              rd_err;

  always #5 clk = ~clk;

  nrs_pilot_demapper #(.DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .v_shift        (v_shift),
    .in_valid       (in_valid),
    .in_sof         (in_sof),
    .in_sym         (in_sym),
    .in_sc          (in_sc),
    .in_re_i        (in_re_i),
    .in_re_q        (in_re_q),
    .demap_read     (demap_read),
    .col            (col),
    .nrs_index_addr (nrs_index_addr),
    .demap_ready    (demap_ready),
    .pilot_valid    (pilot_valid),
    .pilot_i        (pilot_i),
    .pilot_q        (pilot_q),
    .overrun        (overrun),
    .rd_err         (rd_err)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- subframe-level model ----------------
  logic [31:0] m_data [2][4];
  logic [3:0]  m_mask [2];
  bit          m_full [2];
  int          m_vs;
  int          m_rd_bank;
  int          m_rd_cnt;
  bit          m_overrun;

  bit          nx_ready, nx_pv, nx_err, nx_ovr;
  logic [31:0] nx_data;
  bit          ex_ready, ex_pv, ex_err, ex_ovr;
  logic [31:0] ex_data;

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_cycle();
    bit legal;
    bit isa, isb;
    int rb, wb, ent, k0;
    legal = 1'b0;
    rb    = 0;
    if (rst) begin
      m_mask[0] = 4'h0; m_mask[1] = 4'h0;
      m_full[0] = 1'b0; m_full[1] = 1'b0;
      m_vs = 0; m_rd_bank = 0; m_rd_cnt = 0; m_overrun = 1'b0;
      nx_ready = 1'b0; nx_pv = 1'b0; nx_err = 1'b0; nx_ovr = 1'b0; nx_data = '0;
      return;
    end
    nx_ready = m_full[m_rd_bank];
    nx_pv    = demap_read;
    nx_err   = 1'b0;
    if (demap_read) begin
      rb    = (col >= 4'd7) ? 1 : 0;
      isb   = (col == 4'd6) || (col == 4'd13);
      legal = ((col == 4'd5) || (col == 4'd6) || (col == 4'd12) || (col == 4'd13)) &&
              (rb == m_rd_bank) && m_full[rb] && (nrs_index_addr[1] == isb);
      nx_data = legal ? m_data[rb][nrs_index_addr] : 32'h0;
      nx_err  = !legal;
    end
    if (in_valid) begin
      if (in_sof) m_vs = int'(v_shift) % 6;
      isa = (in_sym == 4'd5) || (in_sym == 4'd12);
      isb = (in_sym == 4'd6) || (in_sym == 4'd13);
      if (isa || isb) begin
        k0 = (m_vs + (isb ? 3 : 0)) % 6;
        if ((int'(in_sc) == k0) || (int'(in_sc) == k0 + 6)) begin
          wb  = (in_sym >= 4'd12) ? 1 : 0;
          ent = (isb ? 2 : 0) + ((int'(in_sc) == k0 + 6) ? 1 : 0);
          if (m_full[wb]) begin
            m_overrun = 1'b1;
          end else begin
            m_data[wb][ent] = {in_re_i, in_re_q};
            m_mask[wb][ent] = 1'b1;
            if (m_mask[wb] == 4'hF) m_full[wb] = 1'b1;
          end
        end
      end
    end
    nx_ovr = m_overrun;
    if (legal) begin
      if (m_rd_cnt == 3) begin
        m_full[rb] = 1'b0;
        m_mask[rb] = 4'h0;
        m_rd_bank  = 1 - m_rd_bank;
        m_rd_cnt   = 0;
      end else begin
        m_rd_cnt++;
      end
    end
  endtask

  always @(posedge clk) begin
    ex_ready <= nx_ready;
    ex_pv    <= nx_pv;
    ex_err   <= nx_err;
    ex_ovr   <= nx_ovr;
    ex_data  <= nx_data;
  end

  // Compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_demap_ready", 32'(demap_ready), 32'(ex_ready));
      check("cmp_pilot_valid", 32'(pilot_valid), 32'(ex_pv));
      check("cmp_rd_err",      32'(rd_err),      32'(ex_err));
      check("cmp_overrun",     32'(overrun),     32'(ex_ovr));
      if (ex_pv) begin
        check("cmp_pilot_i", 32'(pilot_i), 32'(ex_data[31:16]));
        check("cmp_pilot_q", 32'(pilot_q), 32'(ex_data[15:0]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    model_cycle();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    demap_read = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Whole subframe; RE real part = {tag, sym, sc}, imaginary = its complement
  task automatic stream(input int tag, input int vs);
    for (int s = 0; s < 14; s++) begin
      for (int c = 0; c < 12; c++) begin
        in_valid = 1'b1;
        in_sof   = (s == 0) && (c == 0);
        v_shift  = 3'(vs);
        in_sym   = 4'(s);
        in_sc    = 4'(c);
        in_re_i  = 16'((tag << 8) | (s << 4) | c);
        in_re_q  = ~in_re_i;
        cycle();
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // One read strobe; demap_read is left high so reads can run back to back
  task automatic rd(input int c, input int idx, input logic [15:0] exp_i,
                    input bit exp_err, input string name);
    demap_read     = 1'b1;
    col            = 4'(c);
    nrs_index_addr = 2'(idx);
    cycle();
    check({name, "_pv"},  32'(pilot_valid), 32'd1);
    check({name, "_i"},   32'(pilot_i),     32'(exp_i));
    check({name, "_err"}, 32'(rd_err),      32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; v_shift = 3'd0; in_valid = 1'b0; in_sof = 1'b0;
    in_sym = 4'd0; in_sc = 4'd0; in_re_i = '0; in_re_q = '0;
    demap_read = 1'b0; col = 4'd0; nrs_index_addr = 2'd0;
    cycle();
    cycle();
    chk_en = 1'b1;
    check("reset_ready",   32'(demap_ready), 32'd0);
    check("reset_pv",      32'(pilot_valid), 32'd0);
    check("reset_overrun", 32'(overrun),     32'd0);
    rst = 1'b0;
    idle(2);

    // 1: v_shift=0, bank0 pilots at sym5 sc0/6, sym6 sc3/9
    stream(1, 0);
    idle(2);
    check("t1_ready", 32'(demap_ready), 32'd1);
    rd(5, 0, 16'h0150, 1'b0, "t1_r0");
    rd(5, 1, 16'h0156, 1'b0, "t1_r1");
    rd(6, 2, 16'h0163, 1'b0, "t1_r2");
    rd(6, 3, 16'h0169, 1'b0, "t1_r3");
    idle(1);
    check("t1_ready_bank1_full", 32'(demap_ready), 32'd1);
    rd(12, 0, 16'h01C0, 1'b0, "t1_b1r0");
    rd(12, 1, 16'h01C6, 1'b0, "t1_b1r1");
    rd(13, 2, 16'h01D3, 1'b0, "t1_b1r2");
    rd(13, 3, 16'h01D9, 1'b0, "t1_b1r3");
    idle(3);
    check("t1_ready_drained", 32'(demap_ready), 32'd0);

    // 2: v_shift=4, sym12 at sc4/10, sym13 at sc1/7
    stream(2, 4);
    idle(2);
    rd(5, 0, 16'h0254, 1'b0, "t2_r0");
    rd(5, 1, 16'h025A, 1'b0, "t2_r1");
    rd(6, 2, 16'h0261, 1'b0, "t2_r2");
    rd(6, 3, 16'h0267, 1'b0, "t2_r3");
    rd(12, 0, 16'h02C4, 1'b0, "t2_b1r0");
    rd(12, 1, 16'h02CA, 1'b0, "t2_b1r1");
    rd(13, 2, 16'h02D1, 1'b0, "t2_b1r2");
    rd(13, 3, 16'h02D7, 1'b0, "t2_b1r3");
    check("t2_ready_at_last_pv", 32'(demap_ready), 32'd1);
    idle(1);
    check("t2_ready_drop", 32'(demap_ready), 32'd0);

    // 3: v_shift=7 behaves as 1
    stream(3, 7);
    idle(2);
    rd(5, 0, 16'h0351, 1'b0, "t3_r0");
    rd(5, 1, 16'h0357, 1'b0, "t3_r1");
    rd(6, 2, 16'h0364, 1'b0, "t3_r2");
    rd(6, 3, 16'h036A, 1'b0, "t3_r3");
    rd(12, 0, 16'h03C1, 1'b0, "t3_b1r0");
    rd(12, 1, 16'h03C7, 1'b0, "t3_b1r1");
    rd(13, 2, 16'h03D4, 1'b0, "t3_b1r2");
    rd(13, 3, 16'h03DA, 1'b0, "t3_b1r3");
    idle(2);

    // 4: second subframe before any read -> overrun, data still from first
    stream(4, 0);
    idle(1);
    check("t4_no_overrun_yet", 32'(overrun), 32'd0);
    stream(5, 0);
    idle(2);
    check("t4_overrun", 32'(overrun), 32'd1);
    rd(5, 0, 16'h0450, 1'b0, "t4_r0");

    // 5: illegal reads leave rd_cnt untouched
    rd(12, 0, 16'h0000, 1'b1, "t5_col12");
    rd(7, 0,  16'h0000, 1'b1, "t5_col7");
    rd(5, 2,  16'h0000, 1'b1, "t5_idx");
    rd(5, 1, 16'h0456, 1'b0, "t5_r1");
    rd(6, 2, 16'h0463, 1'b0, "t5_r2");
    rd(6, 3, 16'h0469, 1'b0, "t5_r3");
    rd(5, 0, 16'h0000, 1'b1, "t5_drained");
    rd(12, 0, 16'h04C0, 1'b0, "t5_b1r0");

    // 6: reset mid-read, then a fresh subframe is served normally
    rd(12, 1, 16'h04C6, 1'b0, "t6_b1r1");
    demap_read = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    check("t6_rst_ready",   32'(demap_ready), 32'd0);
    check("t6_rst_pv",      32'(pilot_valid), 32'd0);
    check("t6_rst_overrun", 32'(overrun),     32'd0);
    rst = 1'b0;
    idle(2);
    stream(6, 2);
    idle(2);
    check("t6_ready", 32'(demap_ready), 32'd1);
    rd(5, 0, 16'h0652, 1'b0, "t6_r0");
    rd(5, 1, 16'h0658, 1'b0, "t6_r1");
    rd(6, 2, 16'h0665, 1'b0, "t6_r2");
    rd(6, 3, 16'h066B, 1'b0, "t6_r3");
    idle(3);
    check("t6_ready_bank1", 32'(demap_ready), 32'd1);
    check("t6_overrun", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
